// File: rtl/result_wr_arbiter.sv
// Write arbiter merging NUM_CH pipeline-stage write streams onto the single
// MFCC result-memory write port, with fixed-select and round-robin modes.
//
// Handshakes:
//   channel side: ch_wen[i] is a request. The channel holds ch_wen/ch_addr/ch_data
//     stable until it sees ch_ack[i] high for one cycle. It may present a new
//     request in the cycle after the ack.
//   memory side:  mem_wen is valid and mem_ready is ready. A write transfers on a
//     rising edge where both are high. While mem_wen=1 and mem_ready=0, every
//     mem_* output holds.
module result_wr_arbiter #(
    parameter int NUM_CH     = 5,
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32,
    parameter int SEL_WIDTH  = 3,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                mode,
    input  logic [SEL_WIDTH-1:0]                addr_sel,
    input  logic [NUM_CH-1:0]                   ch_wen,
    input  logic [NUM_CH*(ADDR_WIDTH+2)-1:0]    ch_addr,
    input  logic [NUM_CH*DATA_WIDTH-1:0]        ch_data,
    output logic [NUM_CH-1:0]                   ch_ack,
    input  logic                                mem_ready,
    output logic                                mem_wen,
    output logic [ADDR_WIDTH+1:0]               mem_addr,
    output logic [DATA_WIDTH-1:0]               mem_data,
    output logic [SEL_WIDTH-1:0]                mem_ch,
    output logic                                sel_err,
    output logic [CNT_WIDTH-1:0]                wr_cnt
);

    localparam int AW = ADDR_WIDTH + 2;
    localparam logic [SEL_WIDTH-1:0] LAST_CH = SEL_WIDTH'(NUM_CH - 1);

    logic                  stage_free;
    logic [NUM_CH-1:0]     eligible;
    logic                  sel_in_range;
    logic                  fix_vld;
    logic [SEL_WIDTH-1:0]  fix_idx;
    logic                  rr_lo_vld;
    logic [SEL_WIDTH-1:0]  rr_lo_idx;
    logic                  rr_hi_vld;
    logic [SEL_WIDTH-1:0]  rr_hi_idx;
    logic                  grant_vld;
    logic [SEL_WIDTH-1:0]  grant_idx;
    logic [NUM_CH-1:0]     ack_nxt;
    logic [AW-1:0]         grant_addr;
    logic [DATA_WIDTH-1:0] grant_data;
    logic [SEL_WIDTH-1:0]  ptr;
    logic [SEL_WIDTH-1:0]  ptr_nxt;

    // A channel being acked still shows its old request this cycle, so it is masked.
    always_comb begin
        stage_free = !mem_wen || mem_ready;
        eligible   = ch_wen & ~ch_ack;
    end

    always_comb begin
        sel_in_range = 1'b0;
        fix_vld      = 1'b0;
        fix_idx      = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (addr_sel == i[SEL_WIDTH-1:0]) begin
                sel_in_range = 1'b1;
                if (eligible[i]) begin
                    fix_vld = 1'b1;
                    fix_idx = i[SEL_WIDTH-1:0];
                end
            end
        end
    end

    // Round-robin: lowest eligible index at or above ptr, else the lowest eligible overall.
    always_comb begin
        rr_lo_vld = 1'b0;
        rr_lo_idx = '0;
        rr_hi_vld = 1'b0;
        rr_hi_idx = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                rr_lo_vld = 1'b1;
                rr_lo_idx = i[SEL_WIDTH-1:0];
                if (i[SEL_WIDTH-1:0] >= ptr) begin
                    rr_hi_vld = 1'b1;
                    rr_hi_idx = i[SEL_WIDTH-1:0];
                end
            end
        end
    end

    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        if (stage_free) begin
            if (!mode) begin
                grant_vld = fix_vld;
                grant_idx = fix_idx;
            end else begin
                grant_vld = rr_lo_vld;
                grant_idx = rr_hi_vld ? rr_hi_idx : rr_lo_idx;
            end
        end
    end

    always_comb begin
        ack_nxt    = '0;
        grant_addr = '0;
        grant_data = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant_idx == i[SEL_WIDTH-1:0]) begin
                ack_nxt[i] = grant_vld;
                grant_addr = ch_addr[i*AW +: AW];
                grant_data = ch_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        ptr_nxt = (grant_idx == LAST_CH) ? '0 : grant_idx + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_wen  <= 1'b0;
            mem_addr <= '0;
            mem_data <= '0;
            mem_ch   <= '0;
            ch_ack   <= '0;
            sel_err  <= 1'b0;
            wr_cnt   <= '0;
            ptr      <= '0;
        end else begin
            ch_ack <= ack_nxt;
            if (grant_vld) begin
                mem_wen  <= 1'b1;
                mem_addr <= grant_addr;
                mem_data <= grant_data;
                mem_ch   <= grant_idx;
            end else if (stage_free) begin
                mem_wen <= 1'b0;
            end
            if (mode && grant_vld) begin
                ptr <= ptr_nxt;
            end
            if (mem_wen && mem_ready) begin
                wr_cnt <= wr_cnt + 1'b1;
            end
            if (!mode && !sel_in_range && (|ch_wen)) begin
                sel_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_result_wr_arbiter.sv
// Randomized and directed bench for result_wr_arbiter against a per-cycle
// reference model plus an expected-write queue.
module tb_result_wr_arbiter;

    localparam int NUM_CH = 5;
    localparam int AW     = 14;
    localparam int DW     = 32;
    localparam int SW     = 3;
    localparam int CW     = 16;
    localparam int EW     = SW + AW + DW;

    logic                 clk;
    logic                 rst_n;
    logic                 mode;
    logic [SW-1:0]        addr_sel;
    logic [NUM_CH-1:0]    ch_wen;
    logic [NUM_CH*AW-1:0] ch_addr;
    logic [NUM_CH*DW-1:0] ch_data;
    logic [NUM_CH-1:0]    ch_ack;
    logic                 mem_ready;
    logic                 mem_wen;
    logic [AW-1:0]        mem_addr;
    logic [DW-1:0]        mem_data;
    logic [SW-1:0]        mem_ch;
    logic                 sel_err;
    logic [CW-1:0]        wr_cnt;

    result_wr_arbiter dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .addr_sel(addr_sel),
        .ch_wen(ch_wen), .ch_addr(ch_addr), .ch_data(ch_data), .ch_ack(ch_ack),
        .mem_ready(mem_ready), .mem_wen(mem_wen), .mem_addr(mem_addr),
        .mem_data(mem_data), .mem_ch(mem_ch), .sel_err(sel_err), .wr_cnt(wr_cnt)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    // driver state
    logic [NUM_CH-1:0] drv_wen;
    logic [AW-1:0]     drv_addr [NUM_CH];
    logic [DW-1:0]     drv_data [NUM_CH];
    logic [NUM_CH-1:0] last_ack;
    int                refill_pct;

    // reference model state
    logic              m_wen;
    logic [AW-1:0]     m_addr;
    logic [DW-1:0]     m_data;
    int                m_ch;
    logic [NUM_CH-1:0] m_ack;
    logic              m_err;
    int                m_cnt;
    int                m_ptr;
    logic [EW-1:0]     exp_q [$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic new_req(input int i);
        drv_wen[i]  = 1'b1;
        drv_addr[i] = AW'($urandom_range(0, (1 << AW) - 1));
        drv_data[i] = $urandom;
    endtask

    task automatic apply();
        for (int i = 0; i < NUM_CH; i++) begin
            ch_wen[i]            = drv_wen[i];
            ch_addr[i*AW +: AW]  = drv_addr[i];
            ch_data[i*DW +: DW]  = drv_data[i];
        end
    endtask

    task automatic model_reset();
        m_wen = 1'b0; m_addr = '0; m_data = '0; m_ch = 0; m_ack = '0;
        m_err = 1'b0; m_cnt = 0; m_ptr = 0;
        last_ack = '0;
        exp_q.delete();
    endtask

    // Computes register contents after the next rising edge from the inputs now applied.
    task automatic model_advance();
        bit free;
        int g;
        free = !m_wen || mem_ready;
        if (m_wen && mem_ready) m_cnt = (m_cnt + 1) % (1 << CW);
        if (!mode && drv_wen != 0 && addr_sel >= NUM_CH) m_err = 1'b1;
        g = -1;
        if (free) begin
            if (!mode) begin
                if (addr_sel < NUM_CH && drv_wen[addr_sel] && !m_ack[addr_sel]) g = int'(addr_sel);
            end else begin
                for (int j = 0; j < NUM_CH; j++) begin
                    int c;
                    c = (m_ptr + j) % NUM_CH;
                    if (g < 0 && drv_wen[c] && !m_ack[c]) g = c;
                end
            end
        end
        m_ack = '0;
        if (g >= 0) begin
            m_ack[g] = 1'b1;
            m_wen    = 1'b1;
            m_addr   = drv_addr[g];
            m_data   = drv_data[g];
            m_ch     = g;
            exp_q.push_back({SW'(g), drv_addr[g], drv_data[g]});
            if (mode) m_ptr = (g + 1) % NUM_CH;
        end else if (free) begin
            m_wen = 1'b0;
        end
    endtask

    task automatic compare_all();
        chk("mem_wen", 64'(mem_wen), 64'(m_wen));
        chk("ch_ack", 64'(ch_ack), 64'(m_ack));
        chk("sel_err", 64'(sel_err), 64'(m_err));
        chk("wr_cnt", 64'(wr_cnt), 64'(m_cnt));
        if (m_wen) begin
            chk("mem_addr", 64'(mem_addr), 64'(m_addr));
            chk("mem_data", 64'(mem_data), 64'(m_data));
            chk("mem_ch", 64'(mem_ch), 64'(m_ch));
        end
    endtask

    // One clock: channel reaction to acks, drive, scoreboard, model, sample.
    task automatic step();
        for (int i = 0; i < NUM_CH; i++) begin
            if (last_ack[i]) begin
                if ($urandom_range(0, 99) < refill_pct) new_req(i);
                else drv_wen[i] = 1'b0;
            end
        end
        last_ack = m_ack;
        apply();
        if (mem_wen && mem_ready) begin
            if (exp_q.size() == 0) chk("sb_empty", 64'(1), 64'(0));
            else chk("sb_write", 64'({mem_ch, mem_addr, mem_data}), 64'(exp_q.pop_front()));
        end
        model_advance();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drv_wen = '0;
        apply();
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        compare_all();
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [AW-1:0] sv_addr;
        logic [DW-1:0] sv_data;
        logic [SW-1:0] sv_ch;
        int            c0;

        rst_n = 1'b0; mode = 1'b0; addr_sel = '0; mem_ready = 1'b1;
        ch_wen = '0; ch_addr = '0; ch_data = '0;
        drv_wen = '0; refill_pct = 0;
        for (int i = 0; i < NUM_CH; i++) begin drv_addr[i] = '0; drv_data[i] = '0; end
        #12;
        do_reset();
        chk("rst_wen", 64'(mem_wen), 64'(0));
        chk("rst_cnt", 64'(wr_cnt), 64'(0));

        // fixed mode single write on channel 2
        mode = 1'b0; addr_sel = 3'd2; refill_pct = 0;
        drv_wen[2] = 1'b1; drv_addr[2] = 14'h0123; drv_data[2] = 32'hDEADBEEF;
        step();
        chk("t1_wen", 64'(mem_wen), 64'(1));
        chk("t1_addr", 64'(mem_addr), 64'h0123);
        chk("t1_data", 64'(mem_data), 64'hDEADBEEF);
        chk("t1_ch", 64'(mem_ch), 64'(2));
        chk("t1_ack", 64'(ch_ack), 64'b00100);
        step();
        chk("t1_cnt", 64'(wr_cnt), 64'(1));
        step();

        // fixed mode: unselected requesters wait
        do_reset();
        mode = 1'b0; addr_sel = 3'd1; refill_pct = 0;
        new_req(0); new_req(2);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("t2_idle_wen", 64'(mem_wen), 64'(0));
            chk("t2_idle_ack", 64'(ch_ack), 64'(0));
        end
        addr_sel = 3'd0;
        step();
        chk("t2_ch0", 64'(mem_ch), 64'(0));
        chk("t2_ack0", 64'(ch_ack), 64'b00001);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("t2_ch2_pending", 64'(ch_ack[2]), 64'(0));
        end

        // round-robin with every channel requesting continuously
        do_reset();
        mode = 1'b1; mem_ready = 1'b1; refill_pct = 100;
        for (int i = 0; i < NUM_CH; i++) new_req(i);
        for (int k = 0; k < 6; k++) begin
            step();
            chk("t3_rr_ch", 64'(mem_ch), 64'(k % NUM_CH));
            chk("t3_rr_ack", 64'(ch_ack), 64'(1 << (k % NUM_CH)));
            chk("t3_rr_wen", 64'(mem_wen), 64'(1));
        end

        // back-pressure for three cycles
        sv_addr = mem_addr; sv_data = mem_data; sv_ch = mem_ch; c0 = int'(wr_cnt);
        mem_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("t4_hold_addr", 64'(mem_addr), 64'(sv_addr));
            chk("t4_hold_data", 64'(mem_data), 64'(sv_data));
            chk("t4_hold_ch", 64'(mem_ch), 64'(sv_ch));
            chk("t4_hold_ack", 64'(ch_ack), 64'(0));
            chk("t4_hold_cnt", 64'(wr_cnt), 64'(c0));
        end
        mem_ready = 1'b1;
        step();
        chk("t4_next_ch", 64'(mem_ch), 64'(1));
        chk("t4_cnt_inc", 64'(wr_cnt), 64'(c0 + 1));

        // illegal fixed select is sticky
        do_reset();
        mode = 1'b0; addr_sel = 3'd6; refill_pct = 0;
        new_req(0);
        step();
        chk("t5_err_set", 64'(sel_err), 64'(1));
        chk("t5_no_wen", 64'(mem_wen), 64'(0));
        addr_sel = 3'd0;
        step();
        chk("t5_err_stuck", 64'(sel_err), 64'(1));
        chk("t5_ch0", 64'(mem_ch), 64'(0));
        chk("t5_wen", 64'(mem_wen), 64'(1));
        step();

        // asynchronous reset mid-write under back-pressure
        do_reset();
        mode = 1'b1; mem_ready = 1'b0; refill_pct = 0;
        new_req(3);
        step();
        chk("t6_wen", 64'(mem_wen), 64'(1));
        step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_wen", 64'(mem_wen), 64'(0));
        chk("t6_rst_ack", 64'(ch_ack), 64'(0));
        chk("t6_rst_addr", 64'(mem_addr), 64'(0));
        chk("t6_rst_data", 64'(mem_data), 64'(0));
        chk("t6_rst_ch", 64'(mem_ch), 64'(0));
        chk("t6_rst_cnt", 64'(wr_cnt), 64'(0));
        model_reset();
        drv_wen = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        mem_ready = 1'b1;
        for (int i = 0; i < NUM_CH; i++) new_req(i);
        step();
        chk("t6_restart_ch", 64'(mem_ch), 64'(0));

        // randomized traffic
        refill_pct = 60;
        for (int k = 0; k < 800; k++) begin
            if ($urandom_range(0, 15) == 0) mode = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) addr_sel = SW'($urandom_range(0, 4));
            if ($urandom_range(0, 199) == 0) addr_sel = SW'($urandom_range(5, 7));
            mem_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < NUM_CH; i++) begin
                if (!drv_wen[i] && $urandom_range(0, 99) < 30) new_req(i);
            end
            step();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/result_wr_arbiter.md
Name: result_wr_arbiter

Overview:
Parametrised write arbiter in front of the MFCC result memory. It merges the write streams of NUM_CH pipeline stages onto one result-memory write port. It supports a fixed mode, where an externally selected channel owns the port, and a round-robin mode for concurrent stages. Writes use a request/acknowledge handshake and pass through one registered output stage, with back-pressure from the memory side.

Parameters:
NUM_CH, 5, number of writer channels (2..8)
ADDR_WIDTH, 12, base address width; every address bus is ADDR_WIDTH+2 bits (14 at default)
DATA_WIDTH, 32, write data width
SEL_WIDTH, 3, width of addr_sel; must satisfy 2^SEL_WIDTH >= NUM_CH
CNT_WIDTH, 16, width of the accepted-write counter

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
mode  input  1  0 = fixed select via addr_sel, 1 = round-robin
addr_sel  input  SEL_WIDTH  owning channel in fixed mode
ch_wen  input  NUM_CH  per-channel write request, bit i = channel i
ch_addr  input  NUM_CH*(ADDR_WIDTH+2)  packed addresses, channel i at slice i
ch_data  input  NUM_CH*DATA_WIDTH  packed write data, channel i at slice i
ch_ack  output  NUM_CH  one-hot acceptance pulse per channel
mem_ready  input  1  result memory accepts a write this cycle
mem_wen  output  1  write valid to result memory
mem_addr  output  ADDR_WIDTH+2  write address
mem_data  output  DATA_WIDTH  write data
mem_ch  output  SEL_WIDTH  source channel of current mem_* write
sel_err  output  1  sticky: fixed mode with addr_sel >= NUM_CH while any ch_wen set
wr_cnt  output  CNT_WIDTH  number of writes accepted by memory

Behaviour:
- Reset (rst_n low, asynchronous): mem_wen=0, mem_addr=0, mem_data=0, mem_ch=0, ch_ack=0, sel_err=0, wr_cnt=0, rr pointer=0. An in-flight write is dropped, and no ack is issued for it.
- Channel protocol: a channel raises ch_wen[i] with stable ch_addr/ch_data and holds them until it sees ch_ack[i]=1 for one cycle. The channel may present a new write in the cycle after the ack.
- Output stage: one register. It is "free" when mem_wen=0, or when mem_wen=1 and mem_ready=1 (draining this cycle).
- Grant is combinational each cycle, and only when the output stage is free:
  - fixed mode: grant channel addr_sel if addr_sel < NUM_CH and ch_wen[addr_sel]=1; otherwise no grant.
  - round-robin: grant the first i with ch_wen[i]=1, searching from ptr upward and wrapping at NUM_CH-1 to 0.
- On grant to k:
  - ch_ack[k]=1 registered, asserted in the cycle after the grant; exactly one bit is set.
  - mem_addr/mem_data/mem_ch load slice k, and mem_wen=1 next cycle.
  - Latency from request-with-free-stage to mem_wen is 1 cycle.
- Because the ack arrives one cycle after the grant, the arbiter masks channel k from arbitration in the ack cycle. This prevents a duplicate grant of the same held request.
- Round-robin pointer: after a grant to k, ptr <= (k+1) mod NUM_CH. The pointer is not updated in fixed mode, and it holds across mode changes.
- Back-pressure: if mem_wen=1 and mem_ready=0, mem_* hold unchanged and no grant occurs.
- If no grant occurs and the stage drains, mem_wen <= 0. mem_addr/mem_data keep their last value.
- Full throughput: while one channel is granted every cycle, mem_wen stays at 1 continuously. Back-to-back writes from the same channel alternate cycles because of the ack mask.
- wr_cnt increments when mem_wen=1 and mem_ready=1, and wraps at 2^CNT_WIDTH-1 to 0.
- sel_err sets when mode=0, addr_sel >= NUM_CH and any ch_wen is set. It clears only on reset.
- Mode or addr_sel change mid-stream: takes effect at the next grant decision. A write already in the output stage completes normally.
- Requests on channels without a grant are held indefinitely. No timeout.

Test Plan:
- Reset then fixed mode, addr_sel=2, ch_wen=5'b00100, addr=14'h0123, data=32'hDEADBEEF, mem_ready=1 -> next cycle mem_wen=1, mem_addr=14'h0123, mem_data=32'hDEADBEEF, mem_ch=2, ch_ack=5'b00100; wr_cnt=1 after the write.
- Fixed mode, addr_sel=1, ch_wen=5'b00101 -> no ack or mem_wen for channels 0/2. Switch addr_sel=0 -> channel 0 is written, and channel 2 stays pending.
- Round-robin, all five channels requesting continuously, mem_ready=1 -> mem_ch sequence 0,1,2,3,4,0; each ch_ack is one cycle wide; no channel is granted twice before the others.
- Round-robin, mem_ready held 0 for 3 cycles with mem_wen=1 -> mem_addr/mem_data/mem_ch stable, no ch_ack; on mem_ready=1 the next grant follows the pointer; wr_cnt increments by exactly 1 per accepted write.
- Fixed mode, addr_sel=3'd6, ch_wen=5'b00001 -> sel_err=1 and stays 1 after addr_sel is corrected; channel 0 is granted once addr_sel=0.
- rst_n pulled low asynchronously mid-write (mem_wen=1, mem_ready=0) -> all outputs 0 immediately; after release, round-robin restarts from channel 0.
